// File: rtl/breakout_pkg.sv
// breakout_pkg
// Shared definitions for the Breakout game controller: state codes,
// output widths, the score ceiling and a saturating score increment.
package breakout_pkg;

    localparam int SCORE_W  = 10;
    localparam int LIVES_W  = 2;
    localparam int LEVEL_W  = 3;
    localparam int PERIOD_W = 20;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_LOST    = 3'd3,
        ST_RESPAWN = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_sequencer_tick_gen.sv
// tick_gen
// Programmable-period strobe generator. The counter runs 0..period-1 while
// enabled, holds while disabled, and is forced to 0 by clear. The period is
// latched on clear and on every wrap, so a new period only applies to the
// interval that starts after the wrap.
// Ports:
//   clock, reset     system clock, async active-low reset
//   enable           count this cycle
//   clear            zero the counter and latch period
//   mask             suppress tick_out for the strobe produced by this wrap
//   period           requested period in cycles
//   tick             one-cycle strobe after each wrap (always)
//   tick_out         tick gated by mask
module tick_gen
    import breakout_pkg::*;
#(
    parameter int BASE_PERIOD = 250000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic                mask,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick,
    output logic                tick_out
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] period_q;
    logic                wrap;

    assign wrap = enable && (count_q == period_q - PERIOD_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            period_q <= PERIOD_W'(BASE_PERIOD);
            tick     <= 1'b0;
            tick_out <= 1'b0;
        end else if (clear) begin
            count_q  <= '0;
            period_q <= period;
            tick     <= 1'b0;
            tick_out <= 1'b0;
        end else if (wrap) begin
            count_q  <= '0;
            period_q <= period;
            tick     <= 1'b1;
            tick_out <= ~mask;
        end else begin
            if (enable) begin
                count_q <= count_q + PERIOD_W'(1);
            end
            tick     <= 1'b0;
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
// Match-flow controller for the Breakout ball datapath. Drives the ball
// mover run level and move strobe and keeps lives, score and speed level.
// Ports:
//   clock, reset           system clock, async active-low reset
//   btn_start, btn_pause   debounced button levels (rising edge acts)
//   endgame, hit_bar       status levels from the ball mover
//   ball_run, move_tick    run level and move strobe to the ball mover
//   lives, score, level    game counters for display
//   game_over, state_led   status for LEDs
//
// state   | meaning
// IDLE    | power-up, waiting for start
// PLAY    | ball moving, strobes issued, hits scored
// PAUSE   | ball frozen, tick count held
// LOST    | one cycle, life taken
// RESPAWN | ball recentring, waiting RESPAWN_TICKS periods
// OVER    | no lives left, waiting for start
module game_sequencer
    import breakout_pkg::*;
#(
    parameter int BASE_PERIOD    = 250000,
    parameter int PERIOD_STEP    = 25000,
    parameter int MAX_LEVEL      = 7,
    parameter int HITS_PER_LEVEL = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_TICKS  = 100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               endgame,
    input  logic               hit_bar,
    output logic               ball_run,
    output logic               move_tick,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic               game_over,
    output logic [2:0]         state_led
);

    localparam int HIT_W  = $clog2(HITS_PER_LEVEL + 1);
    localparam int RESP_W = $clog2(RESPAWN_TICKS + 1);

    state_t state_q, state_nx;

    logic start_q, pause_q, hit_q;
    logic start_edge, pause_edge, hit_edge;

    logic [LIVES_W-1:0]  lives_nx;
    logic [SCORE_W-1:0]  score_nx;
    logic [LEVEL_W-1:0]  level_nx;
    logic [HIT_W-1:0]    hit_cnt_q, hit_cnt_nx;
    logic [RESP_W-1:0]   resp_cnt_q, resp_cnt_nx;

    logic                tick_en, tick_clr, tick_mask;
    logic                tick_int, tick_out;
    logic [PERIOD_W-1:0] period_in;

    assign start_edge = btn_start & ~start_q;
    assign pause_edge = btn_pause & ~pause_q;
    assign hit_edge   = hit_bar   & ~hit_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            pause_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            start_q <= btn_start;
            pause_q <= btn_pause;
            hit_q   <= hit_bar;
        end
    end

    always_comb begin
        state_nx    = state_q;
        lives_nx    = lives;
        score_nx    = score;
        level_nx    = level;
        hit_cnt_nx  = hit_cnt_q;
        resp_cnt_nx = resp_cnt_q;
        tick_en     = 1'b0;
        tick_clr    = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                tick_clr = 1'b1;
                if (start_edge) begin
                    state_nx   = ST_PLAY;
                    lives_nx   = LIVES_W'(LIVES);
                    score_nx   = '0;
                    level_nx   = '0;
                    hit_cnt_nx = '0;
                end
            end
            ST_PLAY: begin
                tick_en = 1'b1;
                if (endgame) begin
                    state_nx = ST_LOST;
                end else if (pause_edge) begin
                    state_nx = ST_PAUSE;
                end else if (hit_edge) begin
                    score_nx = score_inc(score);
                    if (hit_cnt_q == HIT_W'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_nx = '0;
                        if (level < LEVEL_W'(MAX_LEVEL)) begin
                            level_nx = level + LEVEL_W'(1);
                        end
                    end else begin
                        hit_cnt_nx = hit_cnt_q + HIT_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_nx = ST_PLAY;
                end
            end
            ST_LOST: begin
                tick_clr    = 1'b1;
                lives_nx    = lives - LIVES_W'(1);
                resp_cnt_nx = '0;
                state_nx    = (lives == LIVES_W'(1)) ? ST_OVER : ST_RESPAWN;
            end
            ST_RESPAWN: begin
                tick_en = 1'b1;
                if (tick_int) begin
                    if (resp_cnt_q == RESP_W'(RESPAWN_TICKS - 1)) begin
                        resp_cnt_nx = '0;
                        tick_clr    = 1'b1;
                        state_nx    = ST_PLAY;
                    end else begin
                        resp_cnt_nx = resp_cnt_q + RESP_W'(1);
                    end
                end
            end
            default: begin
                tick_clr = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // A strobe is only let out if the ball is still moving next cycle, so
    // nothing reaches the mover on the way into PAUSE, LOST or RESPAWN.
    assign tick_mask = (state_nx != ST_PLAY);

    // Period follows the level being written this cycle, so a game restart
    // from OVER latches the level-0 period rather than the stale one.
    assign period_in = PERIOD_W'(BASE_PERIOD) - PERIOD_W'(level_nx) * PERIOD_W'(PERIOD_STEP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lives      <= LIVES_W'(LIVES);
            score      <= '0;
            level      <= '0;
            hit_cnt_q  <= '0;
            resp_cnt_q <= '0;
            ball_run   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_nx;
            lives      <= lives_nx;
            score      <= score_nx;
            level      <= level_nx;
            hit_cnt_q  <= hit_cnt_nx;
            resp_cnt_q <= resp_cnt_nx;
            ball_run   <= (state_nx == ST_PLAY) || (state_nx == ST_PAUSE);
            game_over  <= (state_nx == ST_OVER);
        end
    end

    assign state_led = state_q;
    assign move_tick = tick_out;

    tick_gen #(
        .BASE_PERIOD (BASE_PERIOD)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (tick_en),
        .clear    (tick_clr),
        .mask     (tick_mask),
        .period   (period_in),
        .tick     (tick_int),
        .tick_out (tick_out)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters
// (period 16, step 2, respawn 3 periods, 2 hits per level).
module tb_game_sequencer;

    logic       clock;
    logic       reset;
    logic       btn_start, btn_pause, endgame, hit_bar;
    logic       ball_run, move_tick, game_over;
    logic [1:0] lives;
    logic [9:0] score;
    logic [2:0] level;
    logic [2:0] state_led;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(
        .BASE_PERIOD    (16),
        .PERIOD_STEP    (2),
        .MAX_LEVEL      (7),
        .HITS_PER_LEVEL (2),
        .LIVES          (3),
        .RESPAWN_TICKS  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .endgame   (endgame),
        .hit_bar   (hit_bar),
        .ball_run  (ball_run),
        .move_tick (move_tick),
        .lives     (lives),
        .score     (score),
        .level     (level),
        .game_over (game_over),
        .state_led (state_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps until move_tick is seen; budget+1 on timeout.
    task automatic wait_tick(input int budget, output int n);
        bit found;
        found = 0;
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            if (!found) begin
                step();
                if (move_tick) begin
                    n = i;
                    found = 1;
                end
            end
        end
    endtask

    // Steps until ball_run is high; also counts strobes seen meanwhile.
    task automatic wait_run(input int budget, output int n, output int ticks);
        bit found;
        found = 0;
        ticks = 0;
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            if (!found) begin
                step();
                if (move_tick) ticks++;
                if (ball_run) begin
                    n = i;
                    found = 1;
                end
            end
        end
    endtask

    initial begin
        int n, m, t;
        reset = 1'b0;
        btn_start = 0; btn_pause = 0; endgame = 0; hit_bar = 0;
        step(); step();

        // reset values
        check("rst_state", state_led, 0);
        check("rst_run", ball_run, 0);
        check("rst_tick", move_tick, 0);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_level", level, 0);
        check("rst_over", game_over, 0);

        reset = 1'b1;
        step(); step();
        check("idle_state", state_led, 0);
        check("idle_run", ball_run, 0);

        // start
        btn_start = 1; step(); btn_start = 0;
        check("start_run", ball_run, 1);
        check("start_state", state_led, 1);
        check("start_lives", lives, 3);
        wait_tick(40, n); check("first_tick", n, 16);
        wait_tick(40, n); check("tick_period1", n, 16);
        wait_tick(40, n); check("tick_period2", n, 16);

        // pause at count 7, hold 50 cycles, resume
        repeat (7) step();
        btn_pause = 1; step(); btn_pause = 0;
        check("pause_state", state_led, 2);
        check("pause_run", ball_run, 1);
        t = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) hit_bar = 1;
            if (i == 20) btn_start = 1;
            if (i == 21) btn_start = 0;
            step();
            if (move_tick) t++;
        end
        check("pause_no_ticks", t, 0);
        check("pause_ignores_start", state_led, 2);
        btn_pause = 1; step(); btn_pause = 0;
        n = 1;
        check("resume_state", state_led, 1);
        wait_tick(40, m);
        check("resume_tick", n + m, 9);
        check("held_hit_no_score", score, 0);
        hit_bar = 0; step();

        // four hits, 5 cycles high each
        for (int h = 0; h < 4; h++) begin
            hit_bar = 1; repeat (5) step();
            hit_bar = 0; repeat (3) step();
            if (h == 1) begin
                check("hits2_score", score, 2);
                check("hits2_level", level, 1);
            end
        end
        check("hits4_score", score, 4);
        check("hits4_level", level, 2);
        wait_tick(40, n);
        wait_tick(40, n); check("level2_period", n, 12);

        // endgame together with a hit edge
        endgame = 1; hit_bar = 1; step();
        check("lost_state", state_led, 3);
        check("lost_run", ball_run, 0);
        check("lost_no_score", score, 4);
        endgame = 0; hit_bar = 0; step();
        check("respawn_state", state_led, 4);
        check("respawn_lives", lives, 2);
        wait_run(200, n, t);
        check("respawn_low_cycles", 2 + n - 1, 38);
        check("respawn_no_ticks", t, 0);
        check("respawn_play", state_led, 1);

        // second life
        endgame = 1; step(); endgame = 0; step();
        check("lost2_lives", lives, 1);
        wait_run(200, n, t);
        check("respawn2_play", state_led, 1);

        // last life
        endgame = 1; step(); endgame = 0;
        check("lost3_state", state_led, 3);
        step();
        check("over_state", state_led, 5);
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);
        check("over_run", ball_run, 0);
        t = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (move_tick) t++;
        end
        check("over_no_ticks", t, 0);

        btn_start = 1; step(); btn_start = 0;
        check("restart_state", state_led, 1);
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);
        check("restart_level", level, 0);
        check("restart_over", game_over, 0);

        // 1000 hits: saturation
        for (int h = 1; h <= 1000; h++) begin
            hit_bar = 1; step();
            hit_bar = 0; step();
            if (h == 13) check("hits13_level", level, 6);
            if (h == 14) check("hits14_level", level, 7);
            if (h == 998) check("hits998_score", score, 998);
            if (h == 999) check("hits999_score", score, 999);
        end
        check("sat_score", score, 999);
        check("sat_level", level, 7);
        check("sat_state", state_led, 1);

        // asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1;
        check("async_state", state_led, 0);
        check("async_score", score, 0);
        check("async_level", level, 0);
        check("async_lives", lives, 3);
        check("async_run", ball_run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the Breakout ball datapath. It owns the match flow: new game, play, pause, life loss, respawn and game over. It sequences the ball mover by driving its run/start level and its move strobe, and counts lives, score and speed level from the mover's `endgame` and `hit_bar` status. It sits between the debounced board buttons and the ball mover; its score, lives and level outputs feed the display and LEDs.

## Interface
Parameters:
- `BASE_PERIOD`, 250000: clock cycles per move strobe at level 0 (100 Hz at 25 MHz); max 2^20-1.
- `PERIOD_STEP`, 25000: cycles removed from the period per level. Requirement: `BASE_PERIOD > MAX_LEVEL*PERIOD_STEP`.
- `MAX_LEVEL`, 7: saturating speed level.
- `HITS_PER_LEVEL`, 4: bar hits per level increment (≥1).
- `LIVES`, 3: lives per game (1..3).
- `RESPAWN_TICKS`, 100: move periods to wait after a lost life.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn_start` in 1: debounced, clock-synchronous level; the rising edge acts.
- `btn_pause` in 1: debounced, clock-synchronous level; the rising edge toggles pause.
- `endgame` in 1: ball reached the bottom (level from the ball mover).
- `hit_bar` in 1: ball overlaps the bar (level, may stay high for several cycles).
- `ball_run` out 1: start level to the ball mover. When low, the mover recentres the ball.
- `move_tick` out 1: one-cycle move strobe to the ball mover.
- `lives` out 2: remaining lives.
- `score` out 10: bar hits this game, saturating at 999.
- `level` out 3: current speed level.
- `game_over` out 1: high in the OVER state.
- `state_led` out 3: current state encoding.

## Operation
- Edge detection: one register each for `btn_start`, `btn_pause` and `hit_bar`. Edge = input & ~registered copy. The registers update every cycle in every state.
- States:
  - IDLE=0: `ball_run`=0. A start edge clears score, level and the hit count, sets `lives`=LIVES, and moves to PLAY.
  - PLAY=1: `ball_run`=1 and the tick generator is enabled. Priority within a cycle: `endgame`=1 → LOST; else pause edge → PAUSE; else a `hit_bar` edge scores.
  - PAUSE=2: `ball_run`=1. The tick counter holds its value and no strobes are issued. A pause edge returns to PLAY. Start edges are ignored.
  - LOST=3: one cycle, `ball_run`=0, `lives` decrements. If the pre-decrement `lives` is 1, go to OVER; else go to RESPAWN.
  - RESPAWN=4: `ball_run`=0. The tick generator runs internally with `move_tick` gated to 0. After RESPAWN_TICKS internal ticks, go to PLAY with the tick counter cleared.
  - OVER=5: `game_over`=1, `ball_run`=0. A start edge reinitialises the game exactly as from IDLE and moves to PLAY.
  - Codes 6 and 7 → IDLE.
- Scoring: on a `hit_bar` edge in PLAY, `score`+1 (held at 999) and hit count +1. When the hit count reaches HITS_PER_LEVEL, it resets to 0 and `level`+1 (held at MAX_LEVEL).
- Scoring is suppressed in the same cycle as `endgame` or a pause edge. A `hit_bar` held high across a pause does not rescore.
- Period: `BASE_PERIOD - level*PERIOD_STEP`, 20-bit unsigned. It is latched when the counter wraps, so a level change takes effect from the next period.

## Timing
- Reset values: state IDLE, `ball_run` 0, `move_tick` 0, `lives`=LIVES, `score` 0, `level` 0, `game_over` 0, `state_led` 0, counters 0, edge registers 0.
- All outputs are registered. A qualifying edge with the input high in cycle N produces the new state and outputs in cycle N+1.
- Tick generation: the counter counts 0..period-1. `move_tick` is high in the cycle after the counter reaches period-1, and the counter returns to 0. The first strobe comes `period` cycles after entering PLAY from IDLE, OVER or RESPAWN.
- Entering PLAY from PAUSE resumes the held count.
- `endgame` seen in PLAY cycle N: `ball_run` is low from N+1 and stays low for at least RESPAWN_TICKS periods, which guarantees the mover recentres.
- `reset` asserted mid-game forces all reset values asynchronously. Release is synchronised by the surrounding reset logic.

## Structure
- `breakout_pkg`: state codes (IDLE..OVER), `SCORE_MAX`=999, and widths for score, lives and level.
- One sub-module, `tick_gen`: programmable period, `enable`, `clear` and hold. It outputs a one-cycle `tick`. The sequencer uses it for both the move strobe and respawn timing.

## Test plan
Benches use `BASE_PERIOD`=16, `PERIOD_STEP`=2, `RESPAWN_TICKS`=3 and `HITS_PER_LEVEL`=2.
- Reset low, then release, then start edge → IDLE outputs at reset; the next cycle shows `ball_run`=1, `state_led`=1 and `lives`=3; the first `move_tick` comes 16 cycles later, then every 16.
- Four separate `hit_bar` pulses, each 5 cycles high → `score`=4, `level`=2, strobe period 12 from the next wrap.
- Pause edge mid-period at count 7 → no strobes for 50 cycles. A second pause edge → the next strobe comes 9 cycles later.
- `endgame` and a `hit_bar` edge in the same cycle → `score` unchanged, LOST for 1 cycle, `lives`=2, `ball_run`=0 for 3×period, then PLAY.
- Three `endgame` events → `lives`=0, `game_over`=1, `state_led`=5. A start edge → `lives`=3, `score`=0, PLAY.
- 1000 hits → `score` holds at 999 and `level` holds at 7.
